// File: rtl/pid_pkg.sv
// -----------------------------------------------------------------------------
// pid_pkg
// Shared constants and types for the PID datapath. It holds the PV sample
// width, the default averaging window of the PV filter and the state type of
// the PV filter.
// No ports (package).
// -----------------------------------------------------------------------------
package pid_pkg;

  localparam int PV_WIDTH           = 4;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

  // EMPTY: the window has no real samples yet, so the next sample primes it.
  // RUN:   the window holds real samples and the moving average is active.
  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } filt_state_t;

endpackage

// File: rtl/pv_filter_median3.sv
// -----------------------------------------------------------------------------
// median3
// Purely combinational median of three unsigned values. The PV filter uses it
// to reject single-sample spikes.
// Ports:
//   a, b, c  in   WIDTH  candidate values
//   med      out  WIDTH  middle value of {a, b, c}
// -----------------------------------------------------------------------------
module median3 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] med
);

  logic [WIDTH-1:0] lo_ab;
  logic [WIDTH-1:0] hi_ab;
  logic [WIDTH-1:0] lo_hc;

  // Formula: median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab = (a < b) ? a : b;
    hi_ab = (a < b) ? b : a;
    lo_hc = (hi_ab < c) ? hi_ab : c;
    med   = (lo_ab > lo_hc) ? lo_ab : lo_hc;
  end

endmodule

// File: rtl/pv_filter.sv
// -----------------------------------------------------------------------------
// pv_filter
// Process-variable conditioning stage. It keeps a moving average over
// 2^DEPTH_LOG2 raw PV samples, using a ring buffer and a running sum. It emits
// the rounded average with a one-cycle valid pulse, which the PID core uses as
// its pv_stb.
// Optional feature: define PV_FILTER_SPIKE_REJECT_EN to put a 3-tap median
// (the new sample plus the last two raw samples) ahead of the averager.
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous reset, active low
//   enable     in   1      low: samples ignored, state held, out_valid = 0
//   flush      in   1      synchronous return to EMPTY
//   in_valid   in   1      strobe: in_pv carries a new sample
//   in_pv      in   WIDTH  raw PV sample, unsigned
//   out_valid  out  1      strobe: out_pv was updated this cycle
//   out_pv     out  WIDTH  filtered PV, unsigned
//   primed     out  1      window holds at least one real sample (state RUN)
// -----------------------------------------------------------------------------
module pv_filter
  import pid_pkg::*;
#(
  parameter int WIDTH      = PV_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pv,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pv,
  output logic             primed
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = WIDTH + DEPTH_LOG2;
  localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

  // The rounding term is half an LSB of the averaged result. It is zero for
  // a window of one sample.
  localparam logic [SW-1:0] HALF = SW'((1 << DEPTH_LOG2) >> 1);

  // The pointer only moves when there is more than one ring slot.
  localparam logic [PW-1:0] PTR_STEP = (DEPTH_LOG2 == 0) ? '0 : PW'(1);

  filt_state_t      state;
  logic [WIDTH-1:0] ring [DEPTH];
  logic [SW-1:0]    sum;
  logic [PW-1:0]    wr_ptr;

  logic             accept;
  logic             prime;
  logic [WIDTH-1:0] feed;
  logic [SW-1:0]    sum_new;
  logic [SW-1:0]    rounded;

`ifdef PV_FILTER_SPIKE_REJECT_EN
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] h0;
  logic [WIDTH-1:0] med;

  median3 #(.WIDTH(WIDTH)) u_median3 (
    .a   (in_pv),
    .b   (h1),
    .c   (h0),
    .med (med)
  );
`endif

  // A priming sample replaces the whole window. It is the first sample
  // accepted in EMPTY, or a sample that arrives together with flush.
  // The window holds only real samples, so the running sum never exceeds
  // DEPTH*(2^WIDTH-1). The half-LSB rounding term therefore fits in SW bits.
  always_comb begin
    accept = in_valid & enable;
    prime  = accept & (flush | (state == EMPTY));
`ifdef PV_FILTER_SPIKE_REJECT_EN
    feed   = prime ? in_pv : med;
`else
    feed   = in_pv;
`endif
    if (prime) begin
      sum_new = SW'(in_pv) << DEPTH_LOG2;
    end else begin
      sum_new = sum + SW'(feed) - SW'(ring[wr_ptr]);
    end
    rounded = sum_new + HALF;
  end

  // The window state and the registered output are updated in one block.
  // Priority order is reset, then priming (which also covers flush with a
  // sample), then flush alone, then a normal accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      out_pv    <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
`ifdef PV_FILTER_SPIKE_REJECT_EN
      h1        <= '0;
      h0        <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (prime) begin
        for (int i = 0; i < DEPTH; i++) ring[i] <= in_pv;
        sum       <= sum_new;
        wr_ptr    <= '0;
        state     <= RUN;
        primed    <= 1'b1;
        out_valid <= 1'b1;
        out_pv    <= WIDTH'(rounded >> DEPTH_LOG2);
`ifdef PV_FILTER_SPIKE_REJECT_EN
        h1        <= in_pv;
        h0        <= in_pv;
`endif
      end else if (flush) begin
        state  <= EMPTY;
        primed <= 1'b0;
      end else if (accept) begin
        ring[wr_ptr] <= feed;
        sum          <= sum_new;
        wr_ptr       <= wr_ptr + PTR_STEP;
        out_valid    <= 1'b1;
        out_pv       <= WIDTH'(rounded >> DEPTH_LOG2);
`ifdef PV_FILTER_SPIKE_REJECT_EN
        h1           <= in_pv;
        h0           <= h1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pv_filter.sv
// -----------------------------------------------------------------------------
// tb_pv_filter
// Directed testbench for pv_filter with the default window (DEPTH_LOG2 = 2,
// four samples). Each expected value is worked out by hand from the moving
// average definition.
// -----------------------------------------------------------------------------
module tb_pv_filter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       flush;
  logic       in_valid;
  logic [3:0] in_pv;
  logic       out_valid;
  logic [3:0] out_pv;
  logic       primed;

  int tests_run;
  int tests_failed;

  pv_filter #(.WIDTH(4), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pv     (in_pv),
    .out_valid (out_valid),
    .out_pv    (out_pv),
    .primed    (primed)
  );

  // Free-running clock with a 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every check is counted here, and each mismatch
  // is reported on its own line.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one sample for a single cycle, optionally together with flush.
  // Inputs change on the falling edge, so the result is registered on the
  // next rising edge and can be sampled on the falling edge that follows.
  task automatic applyStimulus(input logic fl, input logic [3:0] sample);
    @(negedge clk);
    flush    = fl;
    in_valid = 1'b1;
    in_pv    = sample;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    enable   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_pv    = '0;

    #12;
    checkOutput("reset_out_pv", out_pv, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_primed", primed, 0);
    @(negedge clk);
    reset = 1'b1;

    // Priming: window becomes {8,8,8,8}
    applyStimulus(1'b0, 4'd8);
    checkOutput("prime_valid", out_valid, 1);
    checkOutput("prime_pv", out_pv, 8);
    checkOutput("prime_primed", primed, 1);
    @(negedge clk);
    checkOutput("prime_pulse_once", out_valid, 0);

    // Decay: sums 24, 16, 8, 0
    applyStimulus(1'b0, 4'd0);
    checkOutput("decay1_pv", out_pv, 6);
    applyStimulus(1'b0, 4'd0);
    checkOutput("decay2_pv", out_pv, 4);
    applyStimulus(1'b0, 4'd0);
    checkOutput("decay3_pv", out_pv, 2);
    applyStimulus(1'b0, 4'd0);
    checkOutput("decay4_pv", out_pv, 0);
    checkOutput("decay4_valid", out_valid, 1);

    // Rounding: re-prime with 15 (sum 60), then 14 -> sum 59, (59+2)>>2 = 15
    applyStimulus(1'b1, 4'd15);
    checkOutput("reprime15_pv", out_pv, 15);
    applyStimulus(1'b0, 4'd14);
    checkOutput("round_pv", out_pv, 15);

    // Back-to-back: eight consecutive 14s make the pointer wrap twice
    @(negedge clk);
    in_valid = 1'b1;
    in_pv    = 4'd14;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("b2b_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    checkOutput("wrap_pv", out_pv, 14);
    @(negedge clk);
    checkOutput("b2b_idle_valid", out_valid, 0);

    // Flush together with a sample: the sample primes the window
    applyStimulus(1'b1, 4'd3);
    checkOutput("flush_prime_valid", out_valid, 1);
    checkOutput("flush_prime_pv", out_pv, 3);
    checkOutput("flush_prime_primed", primed, 1);

    // enable low: the sample is ignored and the outputs are held
    enable = 1'b0;
    applyStimulus(1'b0, 4'd12);
    checkOutput("disabled_valid", out_valid, 0);
    checkOutput("disabled_pv", out_pv, 3);
    checkOutput("disabled_primed", primed, 1);

    // flush still acts while enable is low; out_pv is held
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_only_primed", primed, 0);
    checkOutput("flush_only_pv", out_pv, 3);
    checkOutput("flush_only_valid", out_valid, 0);
    enable = 1'b1;

    // Spike: prime with 5 (EMPTY state), then a single 15
    applyStimulus(1'b0, 4'd5);
    checkOutput("spike_prime_pv", out_pv, 5);
    applyStimulus(1'b0, 4'd15);
`ifdef PV_FILTER_SPIKE_REJECT_EN
    checkOutput("spike_pv", out_pv, 5);
`else
    checkOutput("spike_pv", out_pv, 8);
`endif

    // Asynchronous reset in mid-run with a nonzero sum, away from any edge
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_pv", out_pv, 0);
    checkOutput("async_reset_primed", primed, 0);
    checkOutput("async_reset_valid", out_valid, 0);

    // No output for a sample presented while reset is held
    applyStimulus(1'b0, 4'd9);
    checkOutput("in_reset_valid", out_valid, 0);
    checkOutput("in_reset_pv", out_pv, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
